// File: rtl/mvm_uart_system.sv
// mvm_uart_system
// Receives a K matrix and x vector over UART, computes the signed
// matrix-vector product y = K*x one row per clock, and returns y over UART.
// Data flow: rx sync -> RX FSM -> KX shift buffer -> compute FSM
// -> pending register -> TX FSM.
module mvm_uart_system #(
   parameter int CLOCKS_PER_PULSE = 20833,
   parameter int BITS_PER_WORD    = 8,
   parameter int PACKET_SIZE_TX   = 13,
   parameter int R                = 8,
   parameter int C                = 8,
   parameter int W_X              = 8,
   parameter int W_K              = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic tx
);

   // ------------------------------------------------------------------
   // Derived sizes
   // ------------------------------------------------------------------
   localparam int W_Y_OUT    = 32;
   localparam int W_Y        = W_X + W_K + $clog2(C);
   localparam int W_KX       = R*C*W_K + C*W_X;
   localparam int N_WORDS_KX = W_KX / BITS_PER_WORD;
   localparam int W_RES      = R*W_Y_OUT;
   localparam int N_WORDS_Y  = W_RES / BITS_PER_WORD;
   localparam int W_KX_BUF   = W_KX - BITS_PER_WORD;
   localparam int N_PAD      = PACKET_SIZE_TX - BITS_PER_WORD - 1;

   localparam int PW = $clog2(CLOCKS_PER_PULSE + 1);
   localparam int BW = $clog2(PACKET_SIZE_TX + 1);
   localparam int KW = $clog2(N_WORDS_KX + 1);
   localparam int YW = $clog2(N_WORDS_Y + 1);
   localparam int RW = $clog2(R + 1);

   localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
   localparam logic [PW-1:0] HALF_LAST  = PW'(CLOCKS_PER_PULSE/2 - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(BITS_PER_WORD - 1);
   localparam logic [BW-1:0] FRAME_LAST = BW'(PACKET_SIZE_TX - 1);
   localparam logic [KW-1:0] KX_LAST    = KW'(N_WORDS_KX - 1);
   localparam logic [YW-1:0] Y_LAST     = YW'(N_WORDS_Y - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(R - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {CP_IDLE, CP_ROW, CP_DONE} cp_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic                     rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic                     rx_fall;

   rx_state_t                rx_state_reg, rx_state_next;
   logic [PW-1:0]            rx_pulse_reg;
   logic [BW-1:0]            rx_bit_reg;
   logic [BITS_PER_WORD-1:0] rx_shift_reg;
   logic                     rx_pulse_done, rx_sample, rx_accept;

   logic [W_KX_BUF-1:0]      kx_shift_reg;
   logic [W_KX-1:0]          kx_full_reg;
   logic [W_KX-1:0]          kx_full_next;
   logic [KW-1:0]            kx_word_reg;
   logic                     kx_valid_reg;

   cp_state_t                cp_state_reg, cp_state_next;
   logic [RW-1:0]            cp_row_reg;
   logic                     cp_write, cp_done;
   logic [W_Y-1:0]           prod [C];
   logic [W_Y-1:0]           row_sum;
   logic [W_Y_OUT-1:0]       row_ext;
   logic [W_RES-1:0]         y_reg;

   logic [W_RES-1:0]         pend_reg;
   logic                     pend_valid_reg;

   tx_state_t                tx_state_reg, tx_state_next;
   logic [PW-1:0]            tx_pulse_reg;
   logic [BW-1:0]            tx_bit_reg;
   logic [YW-1:0]            tx_byte_reg;
   logic [W_RES-1:0]         tx_buf_reg;
   logic [PACKET_SIZE_TX-1:0] tx_frame_reg;
   logic                     tx_reg;
   logic                     tx_pulse_done, tx_bit_done, tx_last;
   logic                     tx_load_new, tx_load_pend, tx_load;
   logic [W_RES-1:0]         tx_src;

   // ------------------------------------------------------------------
   // RX input synchronizer
   // ------------------------------------------------------------------

   // two-flop synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign rx_fall = rx_prev_reg & ~rx_sync_reg;

   // ------------------------------------------------------------------
   // RX state machine
   // ------------------------------------------------------------------

   // RX state register
   always_ff @(posedge clk) begin
      if (rst) rx_state_reg <= RX_IDLE;
      else     rx_state_reg <= rx_state_next;
   end

   // RX next state: half-bit wait validates the start bit, then full-bit steps
   always_comb begin
      rx_state_next = rx_state_reg;
      case (rx_state_reg)
         RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
         RX_START: if (rx_pulse_reg == HALF_LAST)
                      rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_pulse_reg == PULSE_LAST && rx_bit_reg == DATA_LAST)
                      rx_state_next = RX_STOP;
         RX_STOP:  if (rx_pulse_reg == PULSE_LAST) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   // RX outputs: end-of-interval, data-bit sample and byte-accept strobes
   always_comb begin
      rx_pulse_done = 1'b0;
      rx_sample     = 1'b0;
      rx_accept     = 1'b0;
      case (rx_state_reg)
         RX_START: rx_pulse_done = (rx_pulse_reg == HALF_LAST);
         RX_DATA: begin
            rx_pulse_done = (rx_pulse_reg == PULSE_LAST);
            rx_sample     = rx_pulse_done;
         end
         RX_STOP: begin
            rx_pulse_done = (rx_pulse_reg == PULSE_LAST);
            rx_accept     = rx_pulse_done & rx_sync_reg;
         end
         default: ;
      endcase
   end

   // RX counters and LSB-first data shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_pulse_reg <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
      end else begin
         if (rx_state_reg == RX_IDLE || rx_pulse_done) rx_pulse_reg <= '0;
         else                                          rx_pulse_reg <= rx_pulse_reg + 1'b1;

         if (rx_state_reg != RX_DATA) rx_bit_reg <= '0;
         else if (rx_sample)          rx_bit_reg <= rx_bit_reg + 1'b1;

         if (rx_sample) rx_shift_reg <= {rx_sync_reg, rx_shift_reg[BITS_PER_WORD-1:1]};
      end
   end

   // ------------------------------------------------------------------
   // KX buffer: older words drift down so word 0 ends at the bottom
   // ------------------------------------------------------------------
   assign kx_full_next = {rx_shift_reg, kx_shift_reg};

   // collect accepted bytes and hand a complete vector to compute
   always_ff @(posedge clk) begin
      if (rst) begin
         kx_shift_reg <= '0;
         kx_full_reg  <= '0;
         kx_word_reg  <= '0;
         kx_valid_reg <= 1'b0;
      end else begin
         kx_valid_reg <= 1'b0;
         if (rx_accept) begin
            kx_shift_reg <= kx_full_next[W_KX-1:BITS_PER_WORD];
            if (kx_word_reg == KX_LAST) begin
               kx_word_reg  <= '0;
               kx_full_reg  <= kx_full_next;
               kx_valid_reg <= 1'b1;
            end else begin
               kx_word_reg <= kx_word_reg + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Row datapath: C multipliers on the selected row, then a summation
   // Operands are sign-extended to W_Y so plain modular arithmetic is exact.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < C; gi++) begin : g_mul
         logic [W_X-1:0] x_el;
         logic [W_K-1:0] k_el;
         logic [W_Y-1:0] x_ext;
         logic [W_Y-1:0] k_ext;
         assign x_el  = kx_full_reg[gi*W_X +: W_X];
         assign k_el  = kx_full_reg[C*W_X + (int'(cp_row_reg)*C + gi)*W_K +: W_K];
         assign x_ext = {{(W_Y-W_X){x_el[W_X-1]}}, x_el};
         assign k_ext = {{(W_Y-W_K){k_el[W_K-1]}}, k_el};
         assign prod[gi] = x_ext * k_ext;
      end
   endgenerate

   // reduce the row's products; synthesis balances the chain into a tree
   always_comb begin
      row_sum = '0;
      for (int i = 0; i < C; i++) row_sum = row_sum + prod[i];
   end

   assign row_ext = {{(W_Y_OUT-W_Y){row_sum[W_Y-1]}}, row_sum};

   // ------------------------------------------------------------------
   // Compute state machine
   // ------------------------------------------------------------------

   // compute state register
   always_ff @(posedge clk) begin
      if (rst) cp_state_reg <= CP_IDLE;
      else     cp_state_reg <= cp_state_next;
   end

   // compute next state: one clock per row, then a single DONE clock
   always_comb begin
      cp_state_next = cp_state_reg;
      case (cp_state_reg)
         CP_IDLE: if (kx_valid_reg) cp_state_next = CP_ROW;
         CP_ROW:  if (cp_row_reg == ROW_LAST) cp_state_next = CP_DONE;
         CP_DONE: cp_state_next = CP_IDLE;
         default: cp_state_next = CP_IDLE;
      endcase
   end

   // compute outputs: row write enable and result-complete strobe
   always_comb begin
      cp_write = (cp_state_reg == CP_ROW);
      cp_done  = (cp_state_reg == CP_DONE);
   end

   // row counter and result buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         cp_row_reg <= '0;
         y_reg      <= '0;
      end else begin
         if (cp_state_reg != CP_ROW) cp_row_reg <= '0;
         else                        cp_row_reg <= cp_row_reg + 1'b1;
         if (cp_write) y_reg[int'(cp_row_reg)*W_Y_OUT +: W_Y_OUT] <= row_ext;
      end
   end

   // ------------------------------------------------------------------
   // Pending result: only used when TX is busy; newest result wins
   // ------------------------------------------------------------------

   // hold a finished result until TX can take it
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
      end else if (cp_done && tx_state_reg != TX_IDLE) begin
         pend_reg       <= y_reg;
         pend_valid_reg <= 1'b1;
      end else if (tx_load) begin
         pend_valid_reg <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // TX state machine
   // ------------------------------------------------------------------

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) tx_state_reg <= TX_IDLE;
      else     tx_state_reg <= tx_state_next;
   end

   // TX next state: stay in SEND until the last bit of the last byte
   always_comb begin
      tx_state_next = tx_state_reg;
      case (tx_state_reg)
         TX_IDLE: if (cp_done || pend_valid_reg) tx_state_next = TX_SEND;
         TX_SEND: if (tx_last) tx_state_next = TX_IDLE;
         default: tx_state_next = TX_IDLE;
      endcase
   end

   // TX outputs: bit/byte boundaries and load source (fresh result beats pending)
   always_comb begin
      tx_pulse_done = (tx_state_reg == TX_SEND) && (tx_pulse_reg == PULSE_LAST);
      tx_bit_done   = tx_pulse_done && (tx_bit_reg == FRAME_LAST);
      tx_last       = tx_bit_done && (tx_byte_reg == Y_LAST);
      tx_load_new   = (tx_state_reg == TX_IDLE) && cp_done;
      tx_load_pend  = (tx_state_reg == TX_IDLE) && !cp_done && pend_valid_reg;
      tx_load       = tx_load_new | tx_load_pend;
      tx_src        = tx_load_new ? y_reg : pend_reg;
   end

   // TX datapath: frame shift register, byte queue, counters and line driver
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_pulse_reg <= '0;
         tx_bit_reg   <= '0;
         tx_byte_reg  <= '0;
         tx_buf_reg   <= '0;
         tx_frame_reg <= '1;
         tx_reg       <= 1'b1;
      end else begin
         tx_reg <= (tx_state_reg == TX_SEND) ? tx_frame_reg[0] : 1'b1;
         if (tx_load) begin
            tx_pulse_reg <= '0;
            tx_bit_reg   <= '0;
            tx_byte_reg  <= '0;
            tx_buf_reg   <= tx_src >> BITS_PER_WORD;
            tx_frame_reg <= {{N_PAD{1'b1}}, tx_src[BITS_PER_WORD-1:0], 1'b0};
         end else if (tx_state_reg == TX_SEND) begin
            if (tx_pulse_done) begin
               tx_pulse_reg <= '0;
               if (tx_bit_done) begin
                  tx_bit_reg   <= '0;
                  tx_byte_reg  <= tx_byte_reg + 1'b1;
                  tx_buf_reg   <= tx_buf_reg >> BITS_PER_WORD;
                  tx_frame_reg <= {{N_PAD{1'b1}}, tx_buf_reg[BITS_PER_WORD-1:0], 1'b0};
               end else begin
                  tx_bit_reg   <= tx_bit_reg + 1'b1;
                  tx_frame_reg <= {1'b1, tx_frame_reg[PACKET_SIZE_TX-1:1]};
               end
            end else begin
               tx_pulse_reg <= tx_pulse_reg + 1'b1;
            end
         end
      end
   end

   assign tx = tx_reg;

endmodule

// File: tb/tb_mvm_uart_system.sv
// Directed bench for mvm_uart_system: drives 8N1 bytes on rx, decodes tx
// frames with a monitor, and compares the returned bytes to expected values.
module tb_mvm_uart_system;
   localparam int CPP = 4;
   localparam int R   = 8;
   localparam int C   = 8;
   localparam int NKX = 72;
   localparam int NY  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frame_err = 0;
   int send_end = 0;
   int first_cyc;
   int lat;
   logic lat_ok;

   logic [7:0] got_q[$];
   int         got_cyc_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] vec [NKX];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mvm_uart_system #(.CLOCKS_PER_PULSE(CPP)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tx(tx)
   );

   // tx monitor: decode each frame, sampling mid-bit on falling clock edges
   initial begin
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin : frame
            int start_c;
            logic [7:0] b;
            logic bad;
            start_c = cyc;
            bad = 1'b0;
            repeat (2) @(negedge clk);
            if (tx !== 1'b0) bad = 1'b1;
            for (int i = 0; i < 8; i++) begin
               repeat (CPP) @(negedge clk);
               b[i] = tx;
            end
            for (int j = 0; j < 4; j++) begin
               repeat (CPP) @(negedge clk);
               if (tx !== 1'b1) bad = 1'b1;
            end
            if (bad) frame_err++;
            got_q.push_back(b);
            got_cyc_q.push_back(start_c);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPP) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPP) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_vec();
      for (int i = 0; i < NKX; i++) send_byte(vec[i], 1'b1);
      send_end = cyc;
   endtask

   // uniform vector with a hand-computed per-row result pattern
   task automatic load_uniform(input logic [7:0] xv, input logic [7:0] kv,
                               input logic [31:0] yv);
      for (int i = 0; i < NKX; i++) vec[i] = (i < C) ? xv : kv;
      for (int r = 0; r < R; r++)
         for (int b = 0; b < 4; b++) exp_q.push_back(yv[b*8 +: 8]);
   endtask

   // random vector; expected bytes from a direct MVM model
   task automatic load_random();
      int y;
      logic [31:0] yv;
      for (int i = 0; i < NKX; i++) vec[i] = 8'($urandom_range(0, 255));
      for (int r = 0; r < R; r++) begin
         y = 0;
         for (int c = 0; c < C; c++)
            y += int'($signed(vec[C + r*C + c])) * int'($signed(vec[c]));
         yv = y;
         for (int b = 0; b < 4; b++) exp_q.push_back(yv[b*8 +: 8]);
      end
   endtask

   task automatic check_results(input int n, input string tag, output int fc);
      int t;
      logic [7:0] obs;
      logic [7:0] expv;
      t = 0;
      while (got_q.size() < n && t < 3000 + n*60) begin
         @(negedge clk);
         t++;
      end
      checks++;
      assert (got_q.size() >= n) else begin
         errors++;
         $error("FAIL %s_count got %0d bytes exp %0d", tag, got_q.size(), n);
      end
      fc = (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
      for (int i = 0; i < n; i++) begin
         obs = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         if (got_cyc_q.size() > 0) void'(got_cyc_q.pop_front());
         expv = exp_q.pop_front();
         checks++;
         assert (obs === expv) else begin
            errors++;
            $error("FAIL %s_byte%0d got %h exp %h", tag, i, obs, expv);
         end
      end
      $display("%s: %0d bytes checked", tag, n);
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      assert (tx === 1'b1) else begin
         errors++;
         $error("FAIL reset_tx got %b exp 1", tx);
      end
      rst = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      assert (tx === 1'b1) else begin
         errors++;
         $error("FAIL idle_tx got %b exp 1", tx);
      end
      checks++;
      assert (got_q.size() === 0) else begin
         errors++;
         $error("FAIL idle_quiet got %0d frames exp 0", got_q.size());
      end

      // all zeros, plus start latency of the first frame
      load_uniform(8'h00, 8'h00, 32'h0000_0000);
      send_vec();
      check_results(NY, "zeros", first_cyc);
      lat = first_cyc - send_end;
      lat_ok = (lat >= 0 && lat <= R + 4 + CPP);
      checks++;
      assert (lat_ok === 1'b1) else begin
         errors++;
         $error("FAIL latency got %0d clocks exp <= %0d", lat, R + 4 + CPP);
      end
      checks++;
      assert (frame_err === 0) else begin
         errors++;
         $error("FAIL frame_format got %0d bad frames exp 0", frame_err);
      end

      // a byte with a bad stop bit must be dropped, then all ones -> y=8
      send_byte(8'hAA, 1'b0);
      repeat (10) @(negedge clk);
      load_uniform(8'h01, 8'h01, 32'h0000_0008);
      send_vec();
      check_results(NY, "ones", first_cyc);

      // x=-1, k=-128 -> y=1024
      load_uniform(8'hFF, 8'h80, 32'h0000_0400);
      send_vec();
      check_results(NY, "neg_neg", first_cyc);

      // x=-128, k=127 -> y=-130048
      load_uniform(8'h80, 8'h7F, 32'hFFFE_0400);
      send_vec();
      check_results(NY, "neg_pos", first_cyc);

      // ten random vectors with short random gaps
      for (int v = 0; v < 10; v++) begin
         load_random();
         send_vec();
         repeat ($urandom_range(1, 100)) @(negedge clk);
      end
      check_results(10*NY, "random", first_cyc);

      // reset after 30 bytes, then one full vector of ones
      for (int i = 0; i < 30; i++) send_byte(8'h55, 1'b1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      assert (tx === 1'b1) else begin
         errors++;
         $error("FAIL post_reset_tx got %b exp 1", tx);
      end
      repeat (10) @(negedge clk);
      load_uniform(8'h01, 8'h01, 32'h0000_0008);
      send_vec();
      check_results(NY, "after_reset", first_cyc);
      repeat (1500) @(negedge clk);
      checks++;
      assert (got_q.size() === 0) else begin
         errors++;
         $error("FAIL single_result got %0d extra bytes exp 0", got_q.size());
      end
      checks++;
      assert (frame_err === 0) else begin
         errors++;
         $error("FAIL frame_format_end got %0d bad frames exp 0", frame_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
